ram_cam_prio: RTL and testbench
===============================

# ram_cam_prio

Parametrised RAM-based ternary CAM with configurable RAM block width, per-entry erase, a registered lookup pipeline with valid handshake and an optional lowest-address priority encoder. This is the successor to the fixed 7-bit-block CAM. It sits in packet-classification and routing-table paths: a control plane writes or erases entries, and the datapath issues one lookup per clock.

## Interface
Parameters:
- DATA_BLOCKS, 5: number of key slices; each slice maps to one RAM.
- BLOCK_BITS, 7: key bits per slice; each RAM has R = 2^BLOCK_BITS rows.
- ADDR_WIDTH, 5: entry address width; number of entries W = 2^ADDR_WIDTH.
- Derived: DATA_WIDTH = DATA_BLOCKS*BLOCK_BITS.

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- waddr  in  ADDR_WIDTH  entry to write or erase.
- wdata  in  DATA_WIDTH  key value for the entry.
- wcare  in  DATA_WIDTH  care mask; 1 = bit compared, 0 = don't-care.
- wr_erase  in  1  with start_write: 1 = invalidate entry; wdata and wcare are ignored.
- start_write  in  1  one-cycle pulse; sampled only while ready=1.
- ready  out  1  1 = idle; writes and lookups are accepted.
- lookup_valid  in  1  lookup request; sampled only while ready=1.
- lookup_data  in  DATA_WIDTH  search key.
- match_valid  out  1  match outputs are valid this cycle.
- match_lines  out  W  bit i = entry i matches.
- hit  out  1  OR of match_lines.
- match_addr  out  ADDR_WIDTH  lowest matching entry index (see Configuration).

## Operation
- Storage:
  - Slice k holds an R x W RAM.
  - Bit [a][i] = 1 iff entry i accepts slice value a.
  - Entry i matches when all DATA_BLOCKS slices have bit i set.
- State machine: INIT, IDLE, SWEEP.
  - Asynchronous reset enters INIT.
  - INIT: row counter runs 0..R-1, writing all-zero rows, then moves to IDLE.
  - IDLE: ready=1. start_write moves to SWEEP.
  - SWEEP: row counter runs 0..R-1 with read-modify-write on every slice in parallel, then returns to IDLE.
- RMW bit update for row a, slice k, bit waddr:
  - write: bit = ((a ^ wdata_k) & wcare_k) == 0.
  - erase: bit = 0.
  - All other bits of the row are preserved.
  - waddr, wdata, wcare and wr_erase are latched at start_write.
- Overwrite is exact: the sweep clears stale bits, so no erase is needed first.
- Lookup:
  - Each slice reads row lookup_data slice k.
  - The W-bit words are AND-ed across slices to form match_lines.
  - The priority encoder derives match_addr.
- Requests while ready=0: start_write and lookup_valid are dropped silently, with no match_valid.
- start_write and lookup_valid in the same IDLE cycle: the lookup completes against the pre-write table, then the write proceeds.

## Timing
- Reset values: ready=0, match_valid=0, match_lines=0, hit=0, match_addr=0.
- Init: ready rises R+1 cycles after the first posedge with rst_n=1.
- Write/erase: start_write sampled at edge T; ready falls after T and rises after edge T+R+2.
  - A lookup issued on the first cycle after ready rises sees the new entry.
- Lookup latency is 2:
  - lookup_valid sampled at edge N gives match_valid=1 after edge N+2, for one cycle per request.
  - Fully pipelined: back-to-back requests give back-to-back results.
- Outputs when match_valid=0:
  - match_lines, hit and match_addr hold their last values.
  - Bench checks them only when match_valid=1.
- Lookups in flight when a write starts still complete with pre-write data.
- rst_n low mid-sweep:
  - Aborts immediately and clears the pipeline and match_valid.
  - INIT re-runs and the table comes back empty.

## Configuration
- CAM_PRIORITY_EN defined:
  - match_addr is the lowest set index of match_lines.
  - It is registered in the same stage as match_lines, so latency stays 2.
  - match_addr = 0 when hit = 0.
- CAM_PRIORITY_EN undefined:
  - The encoder is not built and match_addr is tied to 0.
  - hit and match_lines are unchanged.

## Test plan
Defaults apply: R=128, W=32, DATA_WIDTH=35. Bench defines CAM_PRIORITY_EN unless noted.
- Reset, then load entries: 0: 0e3d21200/fffffff00; 5: 013d20000/fffff0000; 7: 001050aff/fffffffff; 31: 013d20100/fffffff00 -> ready rises 130 cycles after each start_write.
- Back-to-back lookups 001050aff, 013d21234, 013d20134, 0f3d21212, 0e3d21212 -> results on consecutive cycles:
  - lines 1<<7 (addr 7)
  - 1<<5 (addr 5)
  - (1<<5)|(1<<31) (addr 5, hit=1)
  - 0 (hit=0, addr 0)
  - 1 (addr 0)
- Erase entry 5, then lookup 013d20134 -> lines 1<<31, match_addr 31. Overwrite entry 31 with 0aaaaaaaa/fffffffff -> 013d20134 gives hit=0.
- start_write and lookup_valid while ready=0 -> no match_valid, table unchanged.
- Same-cycle start_write (entry 3, 0f3d21212) and lookup 0f3d21212 -> that lookup misses; a lookup after ready rises hits at addr 3.
- Drop rst_n mid-sweep at row 60 -> outputs zero, ready rises after 129 cycles, all lookups miss. Rebuild without CAM_PRIORITY_EN -> match_addr stays 0.

Source files
------------

// File: rtl/ram_cam_prio.sv
// RAM-based ternary CAM: per-slice R x W bit RAMs, sweep-based write/erase, 2-cycle lookup pipeline.
// Optional lowest-address priority encoder on match_addr, enabled by defining CAM_PRIORITY_EN.
`timescale 1ns/1ps

// state  | meaning
// INIT   | clearing every RAM row after reset; ready=0
// IDLE   | accepting lookups and writes (ready=1 once the last sweep write has landed)
// SWEEP  | read-modify-write of rows 0..R-1 in all slices for the latched entry
module ram_cam_prio #(
    parameter int DATA_BLOCKS = 5,
    parameter int BLOCK_BITS  = 7,
    parameter int ADDR_WIDTH  = 5,
    localparam int DATA_WIDTH = DATA_BLOCKS * BLOCK_BITS,
    localparam int W          = 1 << ADDR_WIDTH,
    localparam int R          = 1 << BLOCK_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] wcare,
    input  logic                  wr_erase,
    input  logic                  start_write,
    output logic                  ready,
    input  logic                  lookup_valid,
    input  logic [DATA_WIDTH-1:0] lookup_data,
    output logic                  match_valid,
    output logic [W-1:0]          match_lines,
    output logic                  hit,
    output logic [ADDR_WIDTH-1:0] match_addr
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    localparam logic [BLOCK_BITS-1:0] ROW_LAST = '1;
    localparam logic [BLOCK_BITS-1:0] ROW_ONE  = 1;

    state_t                state_q, state_d;
    logic [BLOCK_BITS-1:0] row_q, row_d;
    logic                  ready_q, ready_d;

    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0] lat_data_q, lat_data_d;
    logic [DATA_WIDTH-1:0] lat_care_q, lat_care_d;
    logic                  lat_erase_q, lat_erase_d;

    logic                  rmw_vld_q, rmw_vld_d;
    logic [BLOCK_BITS-1:0] rmw_row_q, rmw_row_d;

    logic                  lk_v1_q, lk_v1_d;
    logic                  lk_v2_q, lk_v2_d;
    logic [W-1:0]          ml_s2_q, ml_s2_d;

    logic                  match_valid_q, match_valid_d;
    logic [W-1:0]          match_lines_q, match_lines_d;
    logic                  hit_q, hit_d;

    logic [W-1:0]          mem_q     [DATA_BLOCKS][R];
    logic [W-1:0]          rd_word_q [DATA_BLOCKS];
    logic [BLOCK_BITS-1:0] rd_addr   [DATA_BLOCKS];
    logic                  mem_we;
    logic [BLOCK_BITS-1:0] mem_waddr;
    logic [W-1:0]          mem_wdata [DATA_BLOCKS];
    logic [W-1:0]          and_word;

    logic accept_wr;
    logic accept_lk;

    assign accept_wr = ready_q & start_write;
    assign accept_lk = ready_q & lookup_valid;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        lat_addr_d  = lat_addr_q;
        lat_data_d  = lat_data_q;
        lat_care_d  = lat_care_q;
        lat_erase_d = lat_erase_q;
        case (state_q)
            ST_INIT, ST_SWEEP: begin
                if (row_q == ROW_LAST) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + ROW_ONE;
                end
            end
            ST_IDLE: begin
                if (accept_wr) begin
                    state_d     = ST_SWEEP;
                    row_d       = '0;
                    lat_addr_d  = waddr;
                    lat_data_d  = wdata;
                    lat_care_d  = wcare;
                    lat_erase_d = wr_erase;
                end
            end
            default: begin
                state_d = ST_INIT;
                row_d   = '0;
            end
        endcase
    end

    // Reads lead writes by one cycle during a sweep; ready waits for the final write.
    always_comb begin
        rmw_vld_d = (state_q == ST_SWEEP);
        rmw_row_d = row_q;
        ready_d   = (state_q == ST_IDLE) && !rmw_vld_q && !accept_wr;
    end

    always_comb begin
        for (int k = 0; k < DATA_BLOCKS; k++) begin
            if (state_q == ST_SWEEP) begin
                rd_addr[k] = row_q;
            end else begin
                rd_addr[k] = lookup_data[k*BLOCK_BITS +: BLOCK_BITS];
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = rmw_row_q;
        for (int k = 0; k < DATA_BLOCKS; k++) begin
            mem_wdata[k] = '0;
        end
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = row_q;
        end else if (rmw_vld_q) begin
            mem_we = 1'b1;
            for (int k = 0; k < DATA_BLOCKS; k++) begin
                mem_wdata[k]             = rd_word_q[k];
                mem_wdata[k][lat_addr_q] = !lat_erase_q &&
                    (((rmw_row_q ^ lat_data_q[k*BLOCK_BITS +: BLOCK_BITS]) &
                      lat_care_q[k*BLOCK_BITS +: BLOCK_BITS]) == '0);
            end
        end
    end

    // Plain 1R1W arrays without reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DATA_BLOCKS; k++) begin
            if (mem_we) begin
                mem_q[k][mem_waddr] <= mem_wdata[k];
            end
            rd_word_q[k] <= mem_q[k][rd_addr[k]];
        end
    end

    always_comb begin
        and_word = '1;
        for (int k = 0; k < DATA_BLOCKS; k++) begin
            and_word = and_word & rd_word_q[k];
        end
    end

    always_comb begin
        lk_v1_d       = accept_lk;
        lk_v2_d       = lk_v1_q;
        ml_s2_d       = lk_v1_q ? and_word : ml_s2_q;
        match_valid_d = lk_v2_q;
        match_lines_d = lk_v2_q ? ml_s2_q : match_lines_q;
        hit_d         = lk_v2_q ? (|ml_s2_q) : hit_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            row_q         <= '0;
            ready_q       <= 1'b0;
            lat_addr_q    <= '0;
            lat_data_q    <= '0;
            lat_care_q    <= '0;
            lat_erase_q   <= 1'b0;
            rmw_vld_q     <= 1'b0;
            rmw_row_q     <= '0;
            lk_v1_q       <= 1'b0;
            lk_v2_q       <= 1'b0;
            ml_s2_q       <= '0;
            match_valid_q <= 1'b0;
            match_lines_q <= '0;
            hit_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            ready_q       <= ready_d;
            lat_addr_q    <= lat_addr_d;
            lat_data_q    <= lat_data_d;
            lat_care_q    <= lat_care_d;
            lat_erase_q   <= lat_erase_d;
            rmw_vld_q     <= rmw_vld_d;
            rmw_row_q     <= rmw_row_d;
            lk_v1_q       <= lk_v1_d;
            lk_v2_q       <= lk_v2_d;
            ml_s2_q       <= ml_s2_d;
            match_valid_q <= match_valid_d;
            match_lines_q <= match_lines_d;
            hit_q         <= hit_d;
        end
    end

`ifdef CAM_PRIORITY_EN
    logic [ADDR_WIDTH-1:0] match_addr_q, match_addr_d;

    function automatic logic [ADDR_WIDTH-1:0] lowest_set(input logic [W-1:0] v);
        lowest_set = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = ADDR_WIDTH'(i);
            end
        end
    endfunction

    always_comb begin
        match_addr_d = lk_v2_q ? lowest_set(ml_s2_q) : match_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_addr_q <= '0;
        end else begin
            match_addr_q <= match_addr_d;
        end
    end

    assign match_addr = match_addr_q;
`else
    assign match_addr = '0;
`endif

    assign ready       = ready_q;
    assign match_valid = match_valid_q;
    assign match_lines = match_lines_q;
    assign hit         = hit_q;

endmodule

// File: tb/tb_ram_cam_prio.sv
// Randomized self-checking bench for ram_cam_prio against an entry-list ternary match model.
`timescale 1ns/1ps

module tb_ram_cam_prio;
    localparam int DB = 5;
    localparam int BB = 7;
    localparam int AW = 5;
    localparam int DW = DB * BB;
    localparam int W  = 1 << AW;
    localparam int R  = 1 << BB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] wcare = '0;
    logic          wr_erase = 1'b0;
    logic          start_write = 1'b0;
    logic          ready;
    logic          lookup_valid = 1'b0;
    logic [DW-1:0] lookup_data = '0;
    logic          match_valid;
    logic [W-1:0]  match_lines;
    logic          hit;
    logic [AW-1:0] match_addr;

    always #5 clk = ~clk;

    ram_cam_prio #(.DATA_BLOCKS(DB), .BLOCK_BITS(BB), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .wcare(wcare),
        .wr_erase(wr_erase), .start_write(start_write), .ready(ready),
        .lookup_valid(lookup_valid), .lookup_data(lookup_data),
        .match_valid(match_valid), .match_lines(match_lines), .hit(hit),
        .match_addr(match_addr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference table: one entry per address, matched by plain ternary compare
    bit            m_vld  [W];
    logic [DW-1:0] m_data [W];
    logic [DW-1:0] m_care [W];
    int            rdy_wait = 0;

    bit            p0_v = 0, p1_v = 0;
    logic [W-1:0]  p0_l = '0, p1_l = '0;
    logic [W-1:0]  got_l_q [$];
    logic [AW-1:0] got_a_q [$];

    function automatic logic [DW-1:0] k35(input logic [35:0] v);
        k35 = v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd_dw();
        rnd_dw = DW'({$urandom, $urandom});
    endfunction

    function automatic logic [W-1:0] model_lines(input logic [DW-1:0] key);
        model_lines = '0;
        for (int i = 0; i < W; i++) begin
            model_lines[i] = m_vld[i] && (((key ^ m_data[i]) & m_care[i]) == '0);
        end
    endfunction

    function automatic logic [AW-1:0] model_addr(input logic [W-1:0] l);
        bit found;
        model_addr = '0;
        found = 0;
`ifdef CAM_PRIORITY_EN
        for (int i = 0; i < W; i++) begin
            if (l[i] && !found) begin
                model_addr = AW'(i);
                found = 1;
            end
        end
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < W; i++) begin
            m_vld[i]  = 0;
            m_data[i] = '0;
            m_care[i] = '0;
        end
        p0_v = 0;
        p1_v = 0;
    endtask

    // Called at a falling edge with inputs already set; advances one clock and checks.
    task automatic tick();
        bit           acc_lk, acc_wr, out_v;
        logic [W-1:0] lk_exp, out_l;
        acc_lk = (rdy_wait == 0) && lookup_valid;
        acc_wr = (rdy_wait == 0) && start_write;
        lk_exp = model_lines(lookup_data);
        if (acc_wr) begin
            m_vld[waddr]  = !wr_erase;
            m_data[waddr] = wdata;
            m_care[waddr] = wcare;
        end
        @(posedge clk);
        @(negedge clk);
        out_v = p1_v;
        out_l = p1_l;
        p1_v  = p0_v;
        p1_l  = p0_l;
        p0_v  = acc_lk;
        p0_l  = lk_exp;
        if (acc_wr) rdy_wait = R + 2;
        else if (rdy_wait > 0) rdy_wait--;
        check_eq("ready", ready, rdy_wait == 0);
        check_eq("match_valid", match_valid, out_v);
        if (out_v) begin
            check_eq("match_lines", match_lines, out_l);
            check_eq("hit", hit, |out_l);
            check_eq("match_addr", match_addr, model_addr(out_l));
            got_l_q.push_back(match_lines);
            got_a_q.push_back(match_addr);
        end
    endtask

    task automatic wait_ready(input string tag, input int exp_cnt);
        int cnt;
        cnt = 0;
        while (!ready && cnt < 1000) begin
            tick();
            cnt++;
        end
        check_eq(tag, cnt, exp_cnt);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] c, input bit e,
                            input bit lk, input logic [DW-1:0] key);
        waddr = a; wdata = d; wcare = c; wr_erase = e; start_write = 1'b1;
        lookup_valid = lk; lookup_data = key;
        tick();
        start_write = 1'b0;
        lookup_valid = 1'b0;
        wait_ready("write_ready_latency", R + 2);
    endtask

    logic [DW-1:0] key_q [$];

    task automatic burst();
        got_l_q.delete();
        got_a_q.delete();
        foreach (key_q[i]) begin
            lookup_valid = 1'b1;
            lookup_data  = key_q[i];
            tick();
        end
        lookup_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        rdy_wait = R + 1;
        wait_ready(tag, R + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, ready, 1'b0);
        check_eq({tag, "_match_valid"}, match_valid, 1'b0);
        check_eq({tag, "_match_lines"}, match_lines, '0);
        check_eq({tag, "_hit"}, hit, 1'b0);
        check_eq({tag, "_match_addr"}, match_addr, '0);
    endtask

    logic [W-1:0]  exp_l [5];
    logic [AW-1:0] exp_a [5];

    initial begin
        model_clear();
        exp_l[0] = 32'h1 << 7;
        exp_l[1] = 32'h1 << 5;
        exp_l[2] = (32'h1 << 5) | (32'h1 << 31);
        exp_l[3] = '0;
        exp_l[4] = 32'h1;
`ifdef CAM_PRIORITY_EN
        exp_a[0] = 7; exp_a[1] = 5; exp_a[2] = 5; exp_a[3] = 0; exp_a[4] = 0;
`else
        for (int i = 0; i < 5; i++) exp_a[i] = '0;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        release_reset("init_ready_latency");

        do_write(0,  k35(36'h0e3d21200), k35(36'hfffffff00), 0, 0, '0);
        do_write(5,  k35(36'h013d20000), k35(36'hfffff0000), 0, 0, '0);
        do_write(7,  k35(36'h001050aff), k35(36'hfffffffff), 0, 0, '0);
        do_write(31, k35(36'h013d20100), k35(36'hfffffff00), 0, 0, '0);

        key_q = '{k35(36'h001050aff), k35(36'h013d21234), k35(36'h013d20134),
                  k35(36'h0f3d21212), k35(36'h0e3d21212)};
        burst();
        check_eq("burst_count", got_l_q.size(), 5);
        for (int i = 0; i < 5 && i < got_l_q.size(); i++) begin
            check_eq("burst_lines", got_l_q[i], exp_l[i]);
            check_eq("burst_addr", got_a_q[i], exp_a[i]);
        end

        do_write(5, rnd_dw(), rnd_dw(), 1, 0, '0);
        key_q = '{k35(36'h013d20134)};
        burst();
        check_eq("erase_count", got_l_q.size(), 1);
        if (got_l_q.size() == 1) begin
            check_eq("erase_lines", got_l_q[0], 32'h1 << 31);
`ifdef CAM_PRIORITY_EN
            check_eq("erase_addr", got_a_q[0], 31);
`else
            check_eq("erase_addr", got_a_q[0], 0);
`endif
        end

        do_write(31, k35(36'h0aaaaaaaa), k35(36'hfffffffff), 0, 0, '0);
        key_q = '{k35(36'h013d20134)};
        burst();
        if (got_l_q.size() == 1) check_eq("overwrite_lines", got_l_q[0], '0);
        else check_eq("overwrite_count", got_l_q.size(), 1);

        // requests while busy must be dropped
        waddr = 9; wdata = k35(36'h123456789); wcare = k35(36'hfffffffff);
        wr_erase = 0; start_write = 1;
        tick();
        waddr = 7; wr_erase = 1; lookup_valid = 1; lookup_data = k35(36'h001050aff);
        repeat (20) tick();
        start_write = 0; lookup_valid = 0;
        wait_ready("busy_ready_latency", R + 2 - 20);
        key_q = '{k35(36'h001050aff), k35(36'h123456789)};
        burst();
        check_eq("busy_drop_count", got_l_q.size(), 2);

        do_write(3, k35(36'h0f3d21212), k35(36'hfffffffff), 0, 1, k35(36'h0f3d21212));
        key_q = '{k35(36'h0f3d21212)};
        burst();
        if (got_l_q.size() == 1) check_eq("same_cycle_after_lines", got_l_q[0], 32'h1 << 3);
        else check_eq("same_cycle_after_count", got_l_q.size(), 1);

        // abort a sweep with reset around row 60
        waddr = 12; wdata = rnd_dw(); wcare = rnd_dw(); wr_erase = 0; start_write = 1;
        tick();
        start_write = 0;
        repeat (61) tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(posedge clk);
        release_reset("abort_ready_latency");
        key_q = '{k35(36'h001050aff), k35(36'h0e3d21212), k35(36'h0f3d21212),
                  k35(36'h123456789), k35(36'h0aaaaaaaa)};
        burst();
        foreach (got_l_q[i]) check_eq("abort_lines", got_l_q[i], '0);

        for (int c = 0; c < 6000; c++) begin
            int idx;
            idx = $urandom_range(0, W - 1);
            lookup_valid = ($urandom_range(0, 3) != 0);
            if (m_vld[idx] && $urandom_range(0, 1) == 1)
                lookup_data = m_data[idx] ^ (rnd_dw() & ~m_care[idx]);
            else
                lookup_data = rnd_dw();
            start_write = ($urandom_range(0, 99) == 0);
            waddr    = AW'($urandom);
            wr_erase = ($urandom_range(0, 3) == 0);
            wdata    = rnd_dw();
            wcare    = rnd_dw() | rnd_dw();
            tick();
        end
        start_write = 0;
        lookup_valid = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
